ofs_plat_host_chan_rd_arbiter: RTL and testbench

Round-robin arbiter that shares the c0 (read-request) channel of one host-channel CCI-P port among NUM_REQ AFU-side requesters. Sits between AFU read engines and a single `ports[i]` entry of the host-channel FIU interface. It tags each request's mdata with the requester index, enforces per-requester outstanding-line credit limits and honors c0 almost-full. It steers c0 read responses back to the originating requester.

---
 rtl/ofs_plat_host_chan_rd_arbiter_pkg.sv | 21 ++
 rtl/ofs_plat_host_chan_rd_arbiter_if.sv | 49 ++++
 rtl/ofs_plat_prim_rr_arbiter.sv | 41 ++++
 rtl/ofs_plat_host_chan_rd_arbiter.sv | 104 ++++++++++
 tb/tb_ofs_plat_host_chan_rd_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ofs_plat_host_chan_rd_arbiter_pkg.sv
// Shared types and helpers for the host-channel c0 read-request arbiter.
package ofs_plat_host_chan_rd_arb_pkg;

  typedef logic [1:0] t_cl_len;

  localparam t_cl_len CL_LEN_1       = 2'd0;
  localparam t_cl_len CL_LEN_2       = 2'd1;
  localparam t_cl_len CL_LEN_ILLEGAL = 2'd2;
  localparam t_cl_len CL_LEN_4       = 2'd3;

  typedef logic [7:0] t_outstanding;

  // Width of a requester index, never less than one bit.
  function automatic int tag_width(input int num_req);
    int w;
    w = 1;
    while ((1 << w) < num_req) w++;
    return w;
  endfunction

endpackage

// File: rtl/ofs_plat_host_chan_rd_arbiter_if.sv
// Requester-side and host c0-side bus bundle seen by the read arbiter.
interface ofs_plat_host_chan_rd_arbiter_if
  import ofs_plat_host_chan_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 42,
  parameter int MDATA_W = 16
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr;
  t_cl_len [NUM_REQ-1:0]           req_cl_len;
  logic [NUM_REQ-1:0][MDATA_W-1:0] req_mdata;

  logic                            c0_tx_valid;
  logic [ADDR_W-1:0]               c0_tx_addr;
  t_cl_len                         c0_tx_cl_len;
  logic [MDATA_W-1:0]              c0_tx_mdata;
  logic                            c0_tx_almfull;

  logic                            c0_rx_valid;
  logic [MDATA_W-1:0]              c0_rx_mdata;
  logic [1:0]                      c0_rx_cl_num;
  logic [511:0]                    c0_rx_data;

  logic [NUM_REQ-1:0]              rsp_valid;
  logic [MDATA_W-1:0]              rsp_mdata;
  logic [1:0]                      rsp_cl_num;
  logic [511:0]                    rsp_data;

  modport slave (
    input  req_valid, req_addr, req_cl_len, req_mdata,
    output req_ready,
    output c0_tx_valid, c0_tx_addr, c0_tx_cl_len, c0_tx_mdata,
    input  c0_tx_almfull,
    input  c0_rx_valid, c0_rx_mdata, c0_rx_cl_num, c0_rx_data,
    output rsp_valid, rsp_mdata, rsp_cl_num, rsp_data
  );

  modport master (
    output req_valid, req_addr, req_cl_len, req_mdata,
    input  req_ready,
    input  c0_tx_valid, c0_tx_addr, c0_tx_cl_len, c0_tx_mdata,
    output c0_tx_almfull,
    output c0_rx_valid, c0_rx_mdata, c0_rx_cl_num, c0_rx_data,
    input  rsp_valid, rsp_mdata, rsp_cl_num, rsp_data
  );

endinterface

// File: rtl/ofs_plat_prim_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant, priority rotates past the last advanced grant.
module ofs_plat_prim_rr_arbiter
  import ofs_plat_host_chan_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = tag_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  // Reset to the last index so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     last_grant <= IDX_W'(NUM_REQ - 1);
    else if (advance) last_grant <= grant_idx;
  end

endmodule

// File: rtl/ofs_plat_host_chan_rd_arbiter.sv
// Shares one CCI-P c0 read channel among NUM_REQ requesters with per-requester line credits
// and steers read responses back by the tag carried in the upper mdata bits.
module ofs_plat_host_chan_rd_arbiter
  import ofs_plat_host_chan_rd_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = 42,
  parameter int MDATA_W         = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                              clk,
  input  logic                              reset_n,
  ofs_plat_host_chan_rd_arbiter_if.slave    bus,
  output logic                              idle,
  output logic                              err
);

  localparam int TAG_W = tag_width(NUM_REQ);
  localparam int LOW_W = MDATA_W - TAG_W;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   gidx;
  logic [TAG_W-1:0]   rx_tag;
  logic               hs;
  logic               rx_hit;
  logic               err_set;
  logic               cnt_zero;
  t_cl_len            g_len;
  t_outstanding       cnt      [NUM_REQ];
  t_outstanding       cnt_next [NUM_REQ];

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && !bus.c0_tx_almfull &&
                    ({1'b0, cnt[i]} + {7'b0, bus.req_cl_len[i]} + 9'd1
                     <= 9'(MAX_OUTSTANDING));
    end
  end

  ofs_plat_prim_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (eligible),
    .advance   (hs),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign bus.req_ready = grant;
  assign hs            = |grant;
  assign g_len         = bus.req_cl_len[gidx];
  assign rx_tag        = bus.c0_rx_mdata[MDATA_W-1 -: TAG_W];
  assign rx_hit        = bus.c0_rx_valid && (int'(rx_tag) < NUM_REQ) && (cnt[rx_tag] != '0);
  assign err_set       = (bus.c0_rx_valid && !rx_hit) || (hs && g_len == CL_LEN_ILLEGAL);

  // A grant and a response on the same requester net out in one update.
  always_comb begin
    cnt_zero = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_next[i] = cnt[i];
      if (hs && gidx == TAG_W'(i))     cnt_next[i] = cnt_next[i] + t_outstanding'(g_len) + 8'd1;
      if (rx_hit && rx_tag == TAG_W'(i)) cnt_next[i] = cnt_next[i] - 8'd1;
      cnt_zero = cnt_zero && (cnt_next[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      bus.c0_tx_valid  <= 1'b0;
      bus.c0_tx_addr   <= '0;
      bus.c0_tx_cl_len <= CL_LEN_1;
      bus.c0_tx_mdata  <= '0;
      bus.rsp_valid    <= '0;
      bus.rsp_mdata    <= '0;
      bus.rsp_cl_num   <= '0;
      bus.rsp_data     <= '0;
      idle             <= 1'b1;
      err              <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= cnt_next[i];
      bus.c0_tx_valid <= hs;
      if (hs) begin
        bus.c0_tx_addr   <= bus.req_addr[gidx];
        bus.c0_tx_cl_len <= g_len;
        bus.c0_tx_mdata  <= {gidx, bus.req_mdata[gidx][LOW_W-1:0]};
      end
      bus.rsp_valid <= rx_hit ? (NUM_REQ'(1) << rx_tag) : '0;
      if (bus.c0_rx_valid) begin
        bus.rsp_mdata  <= {{TAG_W{1'b0}}, bus.c0_rx_mdata[LOW_W-1:0]};
        bus.rsp_cl_num <= bus.c0_rx_cl_num;
        bus.rsp_data   <= bus.c0_rx_data;
      end
      idle <= cnt_zero && !hs;
      err  <= err | err_set;
    end
  end

endmodule

// File: tb/tb_ofs_plat_host_chan_rd_arbiter.sv
// Directed bench for the c0 read arbiter: reset, fairness, almost-full, credits, steering, errors.
module tb_ofs_plat_host_chan_rd_arbiter;
  import ofs_plat_host_chan_rd_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 42;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic idle, err;
  int   n_pass = 0;
  int   n_total = 0;

  logic [MW-1:0] exp_md [NR];

  ofs_plat_host_chan_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .MDATA_W(MW)) bus ();

  ofs_plat_host_chan_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .MDATA_W(MW), .MAX_OUTSTANDING(64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .idle    (idle),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid     = '0;
    bus.c0_tx_almfull = 1'b0;
    bus.c0_rx_valid   = 1'b0;
    bus.c0_rx_mdata   = '0;
    bus.c0_rx_cl_num  = '0;
    bus.c0_rx_data    = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i]   = AW'(42'h100 + i);
      bus.req_cl_len[i] = CL_LEN_1;
      bus.req_mdata[i]  = MW'(16'hF000 + i * 17);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_total++; if (bus.c0_tx_valid !== 1'b0) $display("FAIL rst_tx_valid got=%b exp=0", bus.c0_tx_valid); else n_pass++;
    n_total++; if (bus.rsp_valid !== 4'b0) $display("FAIL rst_rsp_valid got=%b exp=0000", bus.rsp_valid); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL rst_idle got=%b exp=1", idle); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL rst_first_grant got=%b exp=0001", bus.req_ready); else n_pass++;
  endtask

  task automatic test_fairness();
    int prev;
    apply_reset();
    bus.req_valid = 4'b1111;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_total++; if (bus.req_ready !== 4'(1 << (k % 4))) $display("FAIL fair_ready k=%0d got=%b exp=%b", k, bus.req_ready, 4'(1 << (k % 4))); else n_pass++;
      if (k > 0) begin
        n_total++; if (bus.c0_tx_valid !== 1'b1 || bus.c0_tx_mdata !== exp_md[prev]) $display("FAIL fair_tx k=%0d got=%b/%h exp=1/%h", k, bus.c0_tx_valid, bus.c0_tx_mdata, exp_md[prev]); else n_pass++;
        n_total++; if (bus.c0_tx_addr !== AW'(42'h100 + prev)) $display("FAIL fair_addr k=%0d got=%h exp=%h", k, bus.c0_tx_addr, AW'(42'h100 + prev)); else n_pass++;
      end
      prev = k % 4;
      @(negedge clk);
    end
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    n_total++; if (bus.c0_tx_valid !== 1'b0) $display("FAIL fair_tx_drop got=%b exp=0", bus.c0_tx_valid); else n_pass++;
  endtask

  task automatic test_almfull();
    apply_reset();
    bus.req_valid = 4'b1111;
    bus.c0_tx_almfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_total++; if (bus.req_ready !== 4'b0 || bus.c0_tx_valid !== 1'b0) $display("FAIL almfull_block k=%0d got=%b/%b exp=0000/0", k, bus.req_ready, bus.c0_tx_valid); else n_pass++;
      @(negedge clk);
    end
    bus.c0_tx_almfull = 1'b0;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL almfull_resume0 got=%b exp=0001", bus.req_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (bus.req_ready !== 4'b0010) $display("FAIL almfull_resume1 got=%b exp=0010", bus.req_ready); else n_pass++;
    n_total++; if (bus.c0_tx_valid !== 1'b1 || bus.c0_tx_mdata !== exp_md[0]) $display("FAIL almfull_tx got=%b/%h exp=1/%h", bus.c0_tx_valid, bus.c0_tx_mdata, exp_md[0]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_credit();
    int good;
    apply_reset();
    bus.req_valid = 4'b0010;
    bus.req_cl_len[1] = CL_LEN_4;
    good = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (bus.req_ready === 4'b0010) good++;
      @(negedge clk);
    end
    n_total++; if (good !== 16) $display("FAIL credit_fill grants got=%0d exp=16", good); else n_pass++;
    #1;
    n_total++; if (bus.req_ready !== 4'b0) $display("FAIL credit_full got=%b exp=0000", bus.req_ready); else n_pass++;
    n_total++; if (bus.c0_tx_cl_len !== 2'd3 || idle !== 1'b0) $display("FAIL credit_tx_len got=%0d idle=%b exp=3 idle=0", bus.c0_tx_cl_len, idle); else n_pass++;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      bus.c0_rx_valid = 1'b1;
      bus.c0_rx_mdata = 16'h4000 + MW'(r);
      #1;
      n_total++; if (bus.req_ready !== 4'b0) $display("FAIL credit_hold r=%0d got=%b exp=0000", r, bus.req_ready); else n_pass++;
    end
    @(negedge clk);
    bus.c0_rx_valid = 1'b0;
    #1;
    n_total++; if (bus.rsp_valid !== 4'b0010) $display("FAIL credit_rsp got=%b exp=0010", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.req_ready !== 4'b0010) $display("FAIL credit_regrant got=%b exp=0010", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  task automatic test_steering();
    apply_reset();
    bus.req_mdata[2] = 16'h0123;
    bus.req_valid = 4'b0100;
    #1;
    n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL steer_grant got=%b exp=0100", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid    = '0;
    bus.c0_rx_valid  = 1'b1;
    bus.c0_rx_mdata  = 16'h8005;
    bus.c0_rx_cl_num = 2'd2;
    bus.c0_rx_data   = {16{32'hDEADBEEF}};
    #1;
    n_total++; if (bus.c0_tx_mdata !== 16'h8123 || idle !== 1'b0) $display("FAIL steer_tx got=%h idle=%b exp=8123 idle=0", bus.c0_tx_mdata, idle); else n_pass++;
    @(negedge clk);
    bus.c0_rx_valid = 1'b0;
    #1;
    n_total++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_mdata !== 16'h0005) $display("FAIL steer_rsp got=%b/%h exp=0100/0005", bus.rsp_valid, bus.rsp_mdata); else n_pass++;
    n_total++; if (bus.rsp_cl_num !== 2'd2 || bus.rsp_data !== {16{32'hDEADBEEF}}) $display("FAIL steer_payload got=%0d/%h exp=2", bus.rsp_cl_num, bus.rsp_data[31:0]); else n_pass++;
    n_total++; if (idle !== 1'b1 || err !== 1'b0) $display("FAIL steer_idle got=%b err=%b exp=1 err=0", idle, err); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (bus.rsp_valid !== 4'b0) $display("FAIL steer_pulse got=%b exp=0000", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_errors();
    // requester 2's counter was drained above, so a second tag-2 line is unexpected
    @(negedge clk);
    bus.c0_rx_valid = 1'b1;
    bus.c0_rx_mdata = 16'h8006;
    @(negedge clk);
    bus.c0_rx_valid = 1'b0;
    #1;
    n_total++; if (bus.rsp_valid !== 4'b0 || err !== 1'b1) $display("FAIL err_underflow got=%b err=%b exp=0000 err=1", bus.rsp_valid, err); else n_pass++;

    apply_reset();
    bus.c0_rx_valid = 1'b1;
    bus.c0_rx_mdata = 16'hC001;
    @(negedge clk);
    bus.c0_rx_valid = 1'b0;
    #1;
    n_total++; if (bus.rsp_valid !== 4'b0 || err !== 1'b1) $display("FAIL err_tag3 got=%b err=%b exp=0000 err=1", bus.rsp_valid, err); else n_pass++;
    repeat (4) @(negedge clk);
    #1;
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err); else n_pass++;

    apply_reset();
    bus.req_valid = 4'b0001;
    bus.req_cl_len[0] = CL_LEN_ILLEGAL;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    n_total++; if (bus.c0_tx_valid !== 1'b1 || bus.c0_tx_cl_len !== 2'd2 || err !== 1'b1) $display("FAIL err_cl_len got=%b/%0d err=%b exp=1/2 err=1", bus.c0_tx_valid, bus.c0_tx_cl_len, err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_cl_len[0] = CL_LEN_1;
    bus.req_valid = 4'b1111;
    bus.c0_rx_valid = 1'b1;
    bus.c0_rx_mdata = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_total++; if (bus.c0_tx_valid !== 1'b1 || bus.rsp_valid !== 4'b0001) $display("FAIL mid_traffic got=%b/%b exp=1/0001", bus.c0_tx_valid, bus.rsp_valid); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++; if (bus.c0_tx_valid !== 1'b0 || bus.rsp_valid !== 4'b0) $display("FAIL mid_rst_out got=%b/%b exp=0/0000", bus.c0_tx_valid, bus.rsp_valid); else n_pass++;
    n_total++; if (err !== 1'b0 || idle !== 1'b1) $display("FAIL mid_rst_status got err=%b idle=%b exp err=0 idle=1", err, idle); else n_pass++;
    bus.c0_rx_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL mid_first_grant got=%b exp=0001", bus.req_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_total++; if (bus.c0_tx_valid !== 1'b1 || bus.c0_tx_mdata !== exp_md[0]) $display("FAIL mid_tx got=%b/%h exp=1/%h", bus.c0_tx_valid, bus.c0_tx_mdata, exp_md[0]); else n_pass++;
    bus.req_valid = '0;
  endtask

  initial begin
    exp_md[0] = 16'h3000;
    exp_md[1] = 16'h7011;
    exp_md[2] = 16'hB022;
    exp_md[3] = 16'hF033;
    test_reset();
    test_fairness();
    test_almfull();
    test_credit();
    test_steering();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
